// File: rtl/bp_l15_req_arbiter.sv
// Round-robin share of the single L1.5 request/response port between the
// D-cache (0) and I-cache (1) transducers; INT_RET is broadcast to both.
//
// state  | meaning
// e_idle | no transaction owned; arbitrate among req_v_i
// e_req  | owner's request presented to L1.5, waiting for ack
// e_resp | request accepted, waiting for the owner's response
module bp_l15_req_arbiter #(
  parameter int addr_width_p = 40,
  parameter int data_width_p = 64
) (
  input  logic                                clk_i,
  input  logic                                reset_n_i,

  input  logic [1:0]                          req_v_i,
  input  logic [1:0][4:0]                     req_rqtype_i,
  input  logic [1:0][2:0]                     req_size_i,
  input  logic [1:0][addr_width_p-1:0]        req_addr_i,
  input  logic [1:0][data_width_p-1:0]        req_data_i,
  input  logic [1:0][1:0]                     req_l1rplway_i,
  output logic [1:0]                          req_ack_o,

  output logic [1:0]                          resp_v_o,
  output logic [3:0]                          resp_returntype_o,
  output logic [63:0]                         resp_data_0_o,
  output logic [63:0]                         resp_data_1_o,
  input  logic [1:0]                          resp_ack_i,

  output logic                                transducer_l15_val,
  output logic [4:0]                          transducer_l15_rqtype,
  output logic [2:0]                          transducer_l15_size,
  output logic [addr_width_p-1:0]             transducer_l15_address,
  output logic [data_width_p-1:0]             transducer_l15_data,
  output logic [1:0]                          transducer_l15_l1rplway,
  input  logic                                l15_transducer_ack,

  input  logic                                l15_transducer_val,
  input  logic [3:0]                          l15_transducer_returntype,
  input  logic [63:0]                         l15_transducer_data_0,
  input  logic [63:0]                         l15_transducer_data_1,
  output logic                                transducer_l15_req_ack
);

  localparam logic [3:0] int_ret_lp = 4'b0111;

  typedef enum logic [1:0] {e_idle, e_req, e_resp} state_e;

  state_e     state_q, state_d;
  logic       grant_q, grant_d;
  logic       last_q, last_d;
  logic [1:0] int_ack_q, int_ack_d;

  logic       is_int;
  logic       winner;
  logic       l15_val_c;
  logic [1:0] req_ack_c;
  logic [1:0] resp_v_c;
  logic       req_ack_l15_c;

  assign is_int = l15_transducer_val & (l15_transducer_returntype == int_ret_lp);
  // Prefer the requester that was not served last.
  assign winner = req_v_i[~last_q] ? ~last_q : last_q;

  always_comb begin
    state_d       = state_q;
    grant_d       = grant_q;
    last_d        = last_q;
    int_ack_d     = int_ack_q;
    l15_val_c     = 1'b0;
    req_ack_c     = 2'b00;
    resp_v_c      = 2'b00;
    req_ack_l15_c = 1'b0;

    case (state_q)
      e_idle: begin
        if (|req_v_i) begin
          grant_d = winner;
          last_d  = winner;
          state_d = e_req;
        end
      end
      e_req: begin
        l15_val_c          = req_v_i[grant_q];
        req_ack_c[grant_q] = l15_transducer_ack;
        if (l15_transducer_ack) state_d = e_resp;
      end
      e_resp: begin
        if (l15_transducer_val && !is_int) begin
          resp_v_c[grant_q] = 1'b1;
          req_ack_l15_c     = resp_ack_i[grant_q];
          if (resp_ack_i[grant_q]) state_d = e_idle;
        end
      end
      default: state_d = e_idle;
    endcase

    // Interrupts are independent of ownership; ack L1.5 once both have taken it.
    if (is_int) begin
      resp_v_c  = ~int_ack_q;
      int_ack_d = int_ack_q | resp_ack_i;
      if (&int_ack_d) begin
        req_ack_l15_c = 1'b1;
        int_ack_d     = 2'b00;
      end
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q   <= e_idle;
      grant_q   <= 1'b0;
      last_q    <= 1'b1;
      int_ack_q <= 2'b00;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      last_q    <= last_d;
      int_ack_q <= int_ack_d;
    end
  end

  always_comb begin
    transducer_l15_val      = 1'b0;
    transducer_l15_rqtype   = '0;
    transducer_l15_size     = '0;
    transducer_l15_address  = '0;
    transducer_l15_data     = '0;
    transducer_l15_l1rplway = '0;
    req_ack_o               = '0;
    resp_v_o                = '0;
    resp_returntype_o       = '0;
    resp_data_0_o           = '0;
    resp_data_1_o           = '0;
    transducer_l15_req_ack  = 1'b0;
    if (reset_n_i) begin
      transducer_l15_val      = l15_val_c;
      transducer_l15_rqtype   = req_rqtype_i[grant_q];
      transducer_l15_size     = req_size_i[grant_q];
      transducer_l15_address  = req_addr_i[grant_q];
      transducer_l15_data     = req_data_i[grant_q];
      transducer_l15_l1rplway = req_l1rplway_i[grant_q];
      req_ack_o               = req_ack_c;
      resp_v_o                = resp_v_c;
      resp_returntype_o       = l15_transducer_returntype;
      resp_data_0_o           = l15_transducer_data_0;
      resp_data_1_o           = l15_transducer_data_1;
      transducer_l15_req_ack  = req_ack_l15_c;
    end
  end

endmodule

// File: tb/tb_bp_l15_req_arbiter.sv
// Directed per-cycle vector table for the L1.5 request arbiter, plus
// hand-written reset sequences.
module tb_bp_l15_req_arbiter;

  localparam logic [3:0] LOAD_RET = 4'b0000;
  localparam logic [3:0] INT_RET  = 4'b0111;
  localparam logic [39:0] ADDR0 = 40'h00_8000_0040;
  localparam logic [39:0] ADDR1 = 40'h00_0000_1080;
  localparam logic [4:0]  RQ0   = 5'b00000;
  localparam logic [4:0]  RQ1   = 5'b00100;

  logic              clk = 1'b0;
  logic              reset_n;
  logic [1:0]        req_v;
  logic [1:0][4:0]   req_rqtype;
  logic [1:0][2:0]   req_size;
  logic [1:0][39:0]  req_addr;
  logic [1:0][63:0]  req_data;
  logic [1:0][1:0]   req_rplway;
  logic [1:0]        req_ack;
  logic [1:0]        resp_v;
  logic [3:0]        resp_rtype;
  logic [63:0]       resp_d0, resp_d1;
  logic [1:0]        resp_ack;
  logic              t_val;
  logic [4:0]        t_rqtype;
  logic [2:0]        t_size;
  logic [39:0]       t_addr;
  logic [63:0]       t_data;
  logic [1:0]        t_rplway;
  logic              l15_ack;
  logic              l15_val;
  logic [3:0]        l15_rtype;
  logic [63:0]       l15_d0, l15_d1;
  logic              t_req_ack;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  bp_l15_req_arbiter #(.addr_width_p(40), .data_width_p(64)) dut (
    .clk_i                     (clk),
    .reset_n_i                 (reset_n),
    .req_v_i                   (req_v),
    .req_rqtype_i              (req_rqtype),
    .req_size_i                (req_size),
    .req_addr_i                (req_addr),
    .req_data_i                (req_data),
    .req_l1rplway_i            (req_rplway),
    .req_ack_o                 (req_ack),
    .resp_v_o                  (resp_v),
    .resp_returntype_o         (resp_rtype),
    .resp_data_0_o             (resp_d0),
    .resp_data_1_o             (resp_d1),
    .resp_ack_i                (resp_ack),
    .transducer_l15_val        (t_val),
    .transducer_l15_rqtype     (t_rqtype),
    .transducer_l15_size       (t_size),
    .transducer_l15_address    (t_addr),
    .transducer_l15_data       (t_data),
    .transducer_l15_l1rplway   (t_rplway),
    .l15_transducer_ack        (l15_ack),
    .l15_transducer_val        (l15_val),
    .l15_transducer_returntype (l15_rtype),
    .l15_transducer_data_0     (l15_d0),
    .l15_transducer_data_1     (l15_d1),
    .transducer_l15_req_ack    (t_req_ack)
  );

  typedef struct {
    logic [1:0] req_v;
    logic       l15_ack;
    logic       l15_val;
    logic [3:0] rtype;
    logic [1:0] resp_ack;
    logic       e_tval;
    logic       e_sel;
    logic [1:0] e_req_ack;
    logic [1:0] e_resp_v;
    logic       e_rack;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic [1:0] rv, input logic ak, input logic lv, input logic [3:0] rt,
                     input logic [1:0] ra, input logic etv, input logic esel,
                     input logic [1:0] era, input logic [1:0] erv, input logic erk);
    vec_t v;
    v.req_v = rv; v.l15_ack = ak; v.l15_val = lv; v.rtype = rt; v.resp_ack = ra;
    v.e_tval = etv; v.e_sel = esel; v.e_req_ack = era; v.e_resp_v = erv; v.e_rack = erk;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  task automatic set_fields();
    req_rqtype = {RQ1, RQ0};
    req_size   = {3'd6, 3'd3};
    req_addr   = {ADDR1, ADDR0};
    req_data   = {64'h1111_2222_3333_4444, 64'hAAAA_BBBB_CCCC_DDDD};
    req_rplway = {2'd2, 2'd1};
    l15_d0     = 64'h0123_4567_89AB_CDEF;
    l15_d1     = 64'hFEDC_BA98_7654_3210;
  endtask

  task automatic clear_ctrl();
    req_v = 2'b00; l15_ack = 1'b0; l15_val = 1'b0; l15_rtype = LOAD_RET; resp_ack = 2'b00;
  endtask

  initial begin
    reset_n = 1'b1;
    set_fields();
    clear_ctrl();
    #2 reset_n = 1'b0;

    // Reset with random inputs: every output is 0.
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      req_v = 2'($urandom); l15_ack = 1'($urandom); l15_val = 1'($urandom);
      l15_rtype = 4'($urandom); resp_ack = 2'($urandom);
      req_addr = {40'($urandom), 40'($urandom)};
      l15_d0 = {$urandom, $urandom}; l15_d1 = {$urandom, $urandom};
      #1;
      check("rst_tval", 64'(t_val), 64'd0);
      check("rst_addr", 64'(t_addr), 64'd0);
      check("rst_rqtype", 64'(t_rqtype), 64'd0);
      check("rst_data", t_data, 64'd0);
      check("rst_req_ack", 64'(req_ack), 64'd0);
      check("rst_resp_v", 64'(resp_v), 64'd0);
      check("rst_resp_d0", resp_d0, 64'd0);
      check("rst_rtype", 64'(resp_rtype), 64'd0);
      check("rst_l15_req_ack", 64'(t_req_ack), 64'd0);
    end
    @(negedge clk);
    set_fields();
    clear_ctrl();
    reset_n = 1'b1;

    //  req   ak lv rtype     rack  tval sel reqack respv rack_o
    add(2'b01, 0, 0, LOAD_RET, 2'b00, 0, 0, 2'b00, 2'b00, 0); // idle -> grant 0
    add(2'b01, 1, 0, LOAD_RET, 2'b00, 1, 0, 2'b01, 2'b00, 0); // first request, acked
    add(2'b00, 0, 0, LOAD_RET, 2'b00, 0, 0, 2'b00, 2'b00, 0);
    add(2'b00, 0, 1, LOAD_RET, 2'b01, 0, 0, 2'b00, 2'b01, 1); // response to 0
    add(2'b11, 0, 0, LOAD_RET, 2'b00, 0, 0, 2'b00, 2'b00, 0); // contention -> grant 1
    add(2'b11, 1, 0, LOAD_RET, 2'b00, 1, 1, 2'b10, 2'b00, 0);
    add(2'b11, 0, 0, LOAD_RET, 2'b00, 0, 0, 2'b00, 2'b00, 0);
    add(2'b11, 0, 0, LOAD_RET, 2'b00, 0, 0, 2'b00, 2'b00, 0);
    add(2'b11, 0, 1, LOAD_RET, 2'b01, 0, 0, 2'b00, 2'b10, 0); // non-owner ack ignored
    add(2'b11, 0, 1, LOAD_RET, 2'b10, 0, 0, 2'b00, 2'b10, 1);
    add(2'b11, 0, 0, LOAD_RET, 2'b00, 0, 0, 2'b00, 2'b00, 0); // -> grant 0
    add(2'b11, 1, 0, LOAD_RET, 2'b00, 1, 0, 2'b01, 2'b00, 0);
    add(2'b11, 0, 1, LOAD_RET, 2'b01, 0, 0, 2'b00, 2'b01, 1);
    add(2'b11, 0, 0, LOAD_RET, 2'b00, 0, 0, 2'b00, 2'b00, 0); // -> grant 1
    for (int i = 0; i < 5; i++)                                  // delayed ack
      add(2'b11, 0, 0, LOAD_RET, 2'b00, 1, 1, 2'b00, 2'b00, 0);
    add(2'b11, 1, 0, LOAD_RET, 2'b00, 1, 1, 2'b10, 2'b00, 0);
    add(2'b00, 1, 0, LOAD_RET, 2'b00, 0, 0, 2'b00, 2'b00, 0); // ack is one pulse only
    add(2'b00, 0, 1, LOAD_RET, 2'b10, 0, 0, 2'b00, 2'b10, 1);
    add(2'b00, 0, 1, INT_RET,  2'b00, 0, 0, 2'b00, 2'b11, 0); // INT_RET in idle
    add(2'b00, 0, 1, INT_RET,  2'b01, 0, 0, 2'b00, 2'b11, 0);
    add(2'b00, 0, 1, INT_RET,  2'b00, 0, 0, 2'b00, 2'b10, 0);
    add(2'b00, 0, 1, INT_RET,  2'b00, 0, 0, 2'b00, 2'b10, 0);
    add(2'b00, 0, 1, INT_RET,  2'b10, 0, 0, 2'b00, 2'b10, 1);
    add(2'b00, 0, 0, LOAD_RET, 2'b00, 0, 0, 2'b00, 2'b00, 0);
    add(2'b10, 0, 0, LOAD_RET, 2'b00, 0, 0, 2'b00, 2'b00, 0); // lone requester 1
    add(2'b10, 1, 0, LOAD_RET, 2'b00, 1, 1, 2'b10, 2'b00, 0);
    add(2'b00, 0, 1, INT_RET,  2'b00, 0, 0, 2'b00, 2'b11, 0); // INT_RET in e_resp
    add(2'b00, 0, 1, INT_RET,  2'b11, 0, 0, 2'b00, 2'b11, 1);
    add(2'b00, 0, 1, LOAD_RET, 2'b00, 0, 0, 2'b00, 2'b10, 0); // still e_resp
    add(2'b00, 0, 1, LOAD_RET, 2'b10, 0, 0, 2'b00, 2'b10, 1);
    add(2'b00, 0, 1, LOAD_RET, 2'b11, 0, 0, 2'b00, 2'b00, 0); // stray resp in idle
    add(2'b00, 0, 0, LOAD_RET, 2'b00, 0, 0, 2'b00, 2'b00, 0);

    foreach (vecs[i]) begin
      @(negedge clk);
      req_v = vecs[i].req_v; l15_ack = vecs[i].l15_ack; l15_val = vecs[i].l15_val;
      l15_rtype = vecs[i].rtype; resp_ack = vecs[i].resp_ack;
      #1;
      check($sformatf("v%0d_tval", i), 64'(t_val), 64'(vecs[i].e_tval));
      check($sformatf("v%0d_req_ack", i), 64'(req_ack), 64'(vecs[i].e_req_ack));
      check($sformatf("v%0d_resp_v", i), 64'(resp_v), 64'(vecs[i].e_resp_v));
      check($sformatf("v%0d_l15_req_ack", i), 64'(t_req_ack), 64'(vecs[i].e_rack));
      check($sformatf("v%0d_rtype", i), 64'(resp_rtype), 64'(vecs[i].rtype));
      if (vecs[i].e_tval) begin
        check($sformatf("v%0d_addr", i), 64'(t_addr), 64'(vecs[i].e_sel ? ADDR1 : ADDR0));
        check($sformatf("v%0d_rqtype", i), 64'(t_rqtype), 64'(vecs[i].e_sel ? RQ1 : RQ0));
      end
    end
    check("resp_d1_pass", resp_d1, 64'hFEDC_BA98_7654_3210);

    // Mid-transaction reset: last winner 0, yet the next grant after reset is 0 again.
    @(negedge clk); clear_ctrl(); req_v = 2'b11; #1;
    check("mr_idle_tval", 64'(t_val), 64'd0);
    @(negedge clk); #1;
    check("mr_req_tval", 64'(t_val), 64'd1);
    check("mr_req_addr", 64'(t_addr), 64'(ADDR0));
    reset_n = 1'b0; #1;
    check("mr_rst_tval", 64'(t_val), 64'd0);
    @(negedge clk); reset_n = 1'b1; #1;
    check("mr_post_idle", 64'(t_val), 64'd0);
    @(negedge clk); #1;
    check("mr_post_tval", 64'(t_val), 64'd1);
    check("mr_post_addr", 64'(t_addr), 64'(ADDR0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
